// File: rtl/agex_pkg.sv
// Shared definitions for the address-generation/execute stage.
// Holds the ALUOP encodings, the condition-code constants and the
// redirect FSM state type used by agex_stage and agex_redirect_ctl.
package agex_pkg;

    localparam int unsigned ALUOP_W = 2;
    localparam int unsigned CC_W    = 3;
    localparam int unsigned DR_W    = 3;
    // Redirect counter width covers REDIRECT_CYCLES-1 for the legal range 1..7
    localparam int unsigned CNT_W   = 3;

    typedef enum logic [ALUOP_W-1:0] {
        OP_BR  = 2'b00,
        OP_ADD = 2'b01,
        OP_LDW = 2'b10,
        OP_STW = 2'b11
    } aluop_e;

    localparam logic [CC_W-1:0] CC_N = 3'b100;
    localparam logic [CC_W-1:0] CC_Z = 3'b010;
    localparam logic [CC_W-1:0] CC_P = 3'b001;

    typedef enum logic {
        RUN      = 1'b0,
        REDIRECT = 1'b1
    } agex_state_e;

endpackage

// File: rtl/agex_redirect_ctl.sv
// Branch-redirect control for the execute stage.
// A taken BR accepted in RUN raises branch_out for REDIRECT_CYCLES cycles;
// while redirecting, squash_c tells the stage to turn incoming instructions
// into bubbles. Everything holds while stall is high.
// Ports:
//   CLK, RESET  clock, asynchronous active-high reset
//   stall       hold all state (MEM cannot accept)
//   br_taken    incoming instruction is a BR with decode's taken bit set
//   branch_out  registered redirect strobe
//   squash_c    combinational: squash the incoming instruction
//   capture_c   combinational: register the branch target this cycle
module agex_redirect_ctl
    import agex_pkg::*;
#(
    parameter int unsigned REDIRECT_CYCLES = 2
) (
    input  logic CLK,
    input  logic RESET,
    input  logic stall,
    input  logic br_taken,
    output logic branch_out,
    output logic squash_c,
    output logic capture_c
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(REDIRECT_CYCLES - 1);

    agex_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             branch_d;

    // State, counter and redirect strobe registers
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            branch_out <= 1'b0;
        end else if (!stall) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            branch_out <= branch_d;
        end
    end

    // Next-state, counter and squash/capture decode
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        branch_d  = branch_out;
        squash_c  = 1'b0;
        capture_c = 1'b0;
        case (state_q)
            RUN: begin
                if (br_taken) begin
                    capture_c = 1'b1;
                    state_d   = REDIRECT;
                    cnt_d     = CNT_LOAD;
                    branch_d  = 1'b1;
                end
            end
            REDIRECT: begin
                squash_c = 1'b1;
                if (cnt_q == '0) begin
                    state_d  = RUN;
                    branch_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d  = RUN;
                branch_d = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/agex_stage.sv
// Address-generation/execute stage of the 5-stage LC-3b-style pipeline.
// Computes the ADD sum, the LDW/STW effective address and the BR target,
// owns the condition codes and drives the fetch redirect / squash window.
// All outputs are registered; MEM_STALL freezes the whole stage.
// Optional feature: define AGEX_OVF_EN to add the sticky ADD_OVF output.
// Ports:
//   CLK, RESET               clock, asynchronous active-high reset
//   OPERAND1/OPERAND2        source/base value, source2/immediate/store data
//   ALUOP, DR, BRANCH        opcode, destination, decode's taken decision
//   PC_IN, PC_OFFSET         instruction PC and sign-extended BR word offset
//   MEM_OFFSET               sign-extended LDW/STW word offset
//   MEM_STALL                hold everything
//   CC_WB_EN, CC_WB_VAL      load writeback condition-code update
//   AGEX_RESULT, STORE_DATA  sum/effective address and store data to MEM
//   OP_EX, DR_EX, MEM_WE     registered opcode, destination, store strobe
//   CC                       architectural {N,Z,P}
//   BRANCH_OUT, TARGET_PC    redirect strobe and target to fetch
//   ADD_OVF                  sticky signed-overflow flag (AGEX_OVF_EN only)
module agex_stage
    import agex_pkg::*;
#(
    parameter int unsigned DATA_W          = 16,
    parameter int unsigned REDIRECT_CYCLES = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [DATA_W-1:0] OPERAND1,
    input  logic [DATA_W-1:0] OPERAND2,
    input  logic [1:0]        ALUOP,
    input  logic [2:0]        DR,
    input  logic              BRANCH,
    input  logic [DATA_W-1:0] PC_IN,
    input  logic [DATA_W-1:0] PC_OFFSET,
    input  logic [DATA_W-1:0] MEM_OFFSET,
    input  logic              MEM_STALL,
    input  logic              CC_WB_EN,
    input  logic [2:0]        CC_WB_VAL,
    output logic [DATA_W-1:0] AGEX_RESULT,
    output logic [DATA_W-1:0] STORE_DATA,
    output logic [1:0]        OP_EX,
    output logic [2:0]        DR_EX,
    output logic              MEM_WE,
    output logic [2:0]        CC,
    output logic              BRANCH_OUT,
    output logic [DATA_W-1:0] TARGET_PC
`ifdef AGEX_OVF_EN
    ,
    output logic              ADD_OVF
`endif
);

    logic              squash_c;
    logic              capture_c;
    logic              br_taken_c;
    logic              is_add_c;
    logic              is_mem_c;
    logic              is_stw_c;
    logic [DATA_W-1:0] sum_c;
    logic [DATA_W-1:0] addr_c;
    logic [DATA_W-1:0] target_c;
    logic [CC_W-1:0]   add_cc_c;

    assign br_taken_c = (ALUOP == OP_BR) && BRANCH;

    agex_redirect_ctl #(
        .REDIRECT_CYCLES (REDIRECT_CYCLES)
    ) u_redirect_ctl (
        .CLK        (CLK),
        .RESET      (RESET),
        .stall      (MEM_STALL),
        .br_taken   (br_taken_c),
        .branch_out (BRANCH_OUT),
        .squash_c   (squash_c),
        .capture_c  (capture_c)
    );

    // Opcode qualifiers; a squashed instruction behaves as a bubble
    assign is_add_c = !squash_c && (ALUOP == OP_ADD);
    assign is_stw_c = !squash_c && (ALUOP == OP_STW);
    assign is_mem_c = !squash_c && ((ALUOP == OP_LDW) || (ALUOP == OP_STW));

    // Datapath arithmetic, modulo 2^DATA_W; offsets are word offsets
    assign sum_c    = OPERAND1 + OPERAND2;
    assign addr_c   = OPERAND1 + (MEM_OFFSET << 1);
    assign target_c = PC_IN + DATA_W'(2) + (PC_OFFSET << 1);

    // Condition codes from the ADD result, exactly one bit set
    always_comb begin
        add_cc_c = CC_P;
        if (sum_c == '0) begin
            add_cc_c = CC_Z;
        end else if (sum_c[DATA_W-1]) begin
            add_cc_c = CC_N;
        end
    end

    // Pipeline output registers
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            AGEX_RESULT <= '0;
            STORE_DATA  <= '0;
            OP_EX       <= OP_BR;
            DR_EX       <= '0;
            MEM_WE      <= 1'b0;
            TARGET_PC   <= '0;
        end else if (!MEM_STALL) begin
            OP_EX  <= OP_BR;
            DR_EX  <= '0;
            MEM_WE <= 1'b0;
            if (is_add_c) begin
                AGEX_RESULT <= sum_c;
                OP_EX       <= OP_ADD;
                DR_EX       <= DR;
            end else if (is_mem_c) begin
                AGEX_RESULT <= addr_c;
                OP_EX       <= ALUOP;
                DR_EX       <= DR;
            end
            if (is_stw_c) begin
                STORE_DATA <= OPERAND2;
                MEM_WE     <= 1'b1;
            end
            if (capture_c) begin
                TARGET_PC <= target_c;
            end
        end
    end

    // Condition codes: the ADD is younger than the load writeback, so it wins
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            CC <= CC_Z;
        end else if (!MEM_STALL) begin
            if (is_add_c) begin
                CC <= add_cc_c;
            end else if (CC_WB_EN) begin
                CC <= CC_WB_VAL;
            end
        end
    end

`ifdef AGEX_OVF_EN
    logic ovf_c;

    // Signed overflow: equal operand signs that differ from the sum's sign
    assign ovf_c = (OPERAND1[DATA_W-1] == OPERAND2[DATA_W-1]) &&
                   (sum_c[DATA_W-1] != OPERAND1[DATA_W-1]);

    // Sticky until reset
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ADD_OVF <= 1'b0;
        end else if (!MEM_STALL && is_add_c && ovf_c) begin
            ADD_OVF <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_agex_stage.sv
// Self-checking bench for agex_stage (DATA_W=16, REDIRECT_CYCLES=2).
// Each driven cycle runs a behavioural model, pushes the expected outputs
// onto a scoreboard queue and pops/compares them one cycle later.
module tb_agex_stage;

    localparam logic [1:0] BR  = 2'b00;
    localparam logic [1:0] ADD = 2'b01;
    localparam logic [1:0] LDW = 2'b10;
    localparam logic [1:0] STW = 2'b11;
    localparam int RC = 2;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [15:0] OPERAND1, OPERAND2, PC_IN, PC_OFFSET, MEM_OFFSET;
    logic [1:0]  ALUOP;
    logic [2:0]  DR, CC_WB_VAL;
    logic        BRANCH, MEM_STALL, CC_WB_EN;
    logic [15:0] AGEX_RESULT, STORE_DATA, TARGET_PC;
    logic [1:0]  OP_EX;
    logic [2:0]  DR_EX, CC;
    logic        MEM_WE, BRANCH_OUT;
    logic        add_ovf_obs;

    typedef struct packed {
        logic [15:0] res;
        logic [15:0] sd;
        logic [15:0] tgt;
        logic [1:0]  op;
        logic [2:0]  dr;
        logic [2:0]  cc;
        logic        we;
        logic        bo;
        logic        ovf;
    } exp_t;

    exp_t m;
    logic m_red;
    int   m_cnt;
    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 CLK = ~CLK;

    agex_stage #(.DATA_W(16), .REDIRECT_CYCLES(RC)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .OPERAND1    (OPERAND1),
        .OPERAND2    (OPERAND2),
        .ALUOP       (ALUOP),
        .DR          (DR),
        .BRANCH      (BRANCH),
        .PC_IN       (PC_IN),
        .PC_OFFSET   (PC_OFFSET),
        .MEM_OFFSET  (MEM_OFFSET),
        .MEM_STALL   (MEM_STALL),
        .CC_WB_EN    (CC_WB_EN),
        .CC_WB_VAL   (CC_WB_VAL),
        .AGEX_RESULT (AGEX_RESULT),
        .STORE_DATA  (STORE_DATA),
        .OP_EX       (OP_EX),
        .DR_EX       (DR_EX),
        .MEM_WE      (MEM_WE),
        .CC          (CC),
        .BRANCH_OUT  (BRANCH_OUT),
        .TARGET_PC   (TARGET_PC)
`ifdef AGEX_OVF_EN
        ,
        .ADD_OVF     (add_ovf_obs)
`endif
    );

`ifndef AGEX_OVF_EN
    assign add_ovf_obs = 1'b0;
`endif

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        m     = '0;
        m.cc  = 3'b010;
        m_red = 1'b0;
        m_cnt = 0;
    endtask

    // Behavioural model of one clock edge
    task automatic model_step(input logic [1:0] alu, input logic [15:0] a, input logic [15:0] b,
                              input logic [2:0] dr, input logic br, input logic [15:0] pc,
                              input logic [15:0] pcoff, input logic [15:0] memoff,
                              input logic stall, input logic wben, input logic [2:0] wbval);
        logic [15:0] sum, addr, tgt;
        logic        sq;
        if (stall) return;
        sum  = a + b;
        addr = a + {memoff[14:0], 1'b0};
        tgt  = pc + 16'd2 + {pcoff[14:0], 1'b0};
        sq   = m_red;
        m.op = 2'b00;
        m.dr = 3'd0;
        m.we = 1'b0;
        if (!sq) begin
            if (alu == ADD) begin
                m.res = sum; m.op = ADD; m.dr = dr;
                if (a[15] == b[15] && sum[15] != a[15]) m.ovf = 1'b1;
            end else if (alu == LDW || alu == STW) begin
                m.res = addr; m.op = alu; m.dr = dr;
            end
            if (alu == STW) begin
                m.sd = b; m.we = 1'b1;
            end
        end
        if (!sq && alu == ADD) m.cc = (sum == 16'd0) ? 3'b010 : (sum[15] ? 3'b100 : 3'b001);
        else if (wben)         m.cc = wbval;
        if (m_red) begin
            if (m_cnt == 0) m_red = 1'b0;
            else            m_cnt--;
        end else if (alu == BR && br) begin
            m_red = 1'b1;
            m_cnt = RC - 1;
            m.tgt = tgt;
        end
        m.bo = m_red;
    endtask

    task automatic compare_outputs(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 16'd0, 16'd1);
            return;
        end
        e = sb.pop_front();
        check({tag, ".res"}, AGEX_RESULT, e.res);
        check({tag, ".sd"},  STORE_DATA, e.sd);
        check({tag, ".tgt"}, TARGET_PC, e.tgt);
        check({tag, ".op"},  16'(OP_EX), 16'(e.op));
        check({tag, ".dr"},  16'(DR_EX), 16'(e.dr));
        check({tag, ".cc"},  16'(CC), 16'(e.cc));
        check({tag, ".we"},  16'(MEM_WE), 16'(e.we));
        check({tag, ".bo"},  16'(BRANCH_OUT), 16'(e.bo));
`ifdef AGEX_OVF_EN
        check({tag, ".ovf"}, 16'(add_ovf_obs), 16'(e.ovf));
`endif
    endtask

    // Drive one instruction, queue the expectation, compare after the edge
    task automatic cycle(input string tag, input logic [1:0] alu, input logic [15:0] a,
                         input logic [15:0] b, input logic [2:0] dr, input logic br,
                         input logic [15:0] pc, input logic [15:0] pcoff,
                         input logic [15:0] memoff, input logic stall,
                         input logic wben, input logic [2:0] wbval);
        ALUOP = alu; OPERAND1 = a; OPERAND2 = b; DR = dr; BRANCH = br;
        PC_IN = pc; PC_OFFSET = pcoff; MEM_OFFSET = memoff;
        MEM_STALL = stall; CC_WB_EN = wben; CC_WB_VAL = wbval;
        model_step(alu, a, b, dr, br, pc, pcoff, memoff, stall, wben, wbval);
        sb.push_back(m);
        @(posedge CLK);
        #1;
        compare_outputs(tag);
    endtask

    initial begin
        RESET = 1'b1;
        ALUOP = BR; OPERAND1 = '0; OPERAND2 = '0; DR = '0; BRANCH = 1'b0;
        PC_IN = '0; PC_OFFSET = '0; MEM_OFFSET = '0;
        MEM_STALL = 1'b0; CC_WB_EN = 1'b0; CC_WB_VAL = '0;
        model_reset();
        #12;
        RESET = 1'b0;

        check("rst.op",  16'(OP_EX), 16'd0);
        check("rst.cc",  16'(CC), 16'h0002);
        check("rst.bo",  16'(BRANCH_OUT), 16'd0);
        check("rst.res", AGEX_RESULT, 16'd0);
        check("rst.sd",  STORE_DATA, 16'd0);
        check("rst.tgt", TARGET_PC, 16'd0);
        check("rst.we",  16'(MEM_WE), 16'd0);

        cycle("idle",    BR,  16'h0000, 16'h0000, 3'd0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 3'b000);
        cycle("add_neg", ADD, 16'h7FFF, 16'h0001, 3'd3, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 3'b000);
        cycle("stw",     STW, 16'h3000, 16'hBEEF, 3'd0, 1'b0, 16'h0000, 16'h0000, 16'hFFFE, 1'b0, 1'b0, 3'b000);
        cycle("stw_end", BR,  16'h0000, 16'h0000, 3'd0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 3'b000);
        cycle("ldw",     LDW, 16'h1000, 16'h5555, 3'd5, 1'b0, 16'h0000, 16'h0000, 16'h0003, 1'b0, 1'b0, 3'b000);

        // Taken branch followed by two ADDs that must be squashed
        cycle("br",      BR,  16'h0000, 16'h0000, 3'd7, 1'b1, 16'h0010, 16'h0004, 16'h0000, 1'b0, 1'b0, 3'b000);
        cycle("sq_add1", ADD, 16'h0001, 16'h0001, 3'd1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 3'b000);
        cycle("sq_add2", ADD, 16'h8000, 16'h8000, 3'd2, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 3'b000);
        cycle("br_nt",   BR,  16'h0000, 16'h0000, 3'd0, 1'b0, 16'h0040, 16'h0010, 16'h0000, 1'b0, 1'b0, 3'b000);

        // CC priority: ADD beats writeback; writeback alone loads, unchecked
        cycle("add_z_wb", ADD, 16'h0005, 16'hFFFB, 3'd4, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 3'b100);
        cycle("wb_p",     BR,  16'h0000, 16'h0000, 3'd0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 3'b001);
        cycle("wb_bad",   BR,  16'h0000, 16'h0000, 3'd0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 3'b111);

        // Stall inside the redirect window
        cycle("br2",     BR,  16'h0000, 16'h0000, 3'd0, 1'b1, 16'h0100, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 3'b000);
        for (int i = 0; i < 3; i++) begin
            cycle("stall", ADD, 16'h0002, 16'h0003, 3'd6, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b1, 3'b100);
        end
        cycle("sq_add3", ADD, 16'h0002, 16'h0003, 3'd6, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 3'b000);
        cycle("br_ign",  BR,  16'h0000, 16'h0000, 3'd0, 1'b1, 16'h0200, 16'h0008, 16'h0000, 1'b0, 1'b0, 3'b000);
        cycle("run",     BR,  16'h0000, 16'h0000, 3'd0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 3'b000);

        // Asynchronous reset in the middle of a redirect
        cycle("br3",     BR,  16'h0000, 16'h0000, 3'd0, 1'b1, 16'h0020, 16'h0001, 16'h0000, 1'b0, 1'b0, 3'b000);
        #2;
        RESET = 1'b1;
        #1;
        check("arst.bo",  16'(BRANCH_OUT), 16'd0);
        check("arst.tgt", TARGET_PC, 16'd0);
        check("arst.cc",  16'(CC), 16'h0002);
        check("arst.res", AGEX_RESULT, 16'd0);
        model_reset();
        sb.delete();
        #3;
        RESET = 1'b0;
        cycle("post_rst", BR,  16'h0000, 16'h0000, 3'd0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 3'b000);
        cycle("add_pos",  ADD, 16'h8000, 16'hFFFF, 3'd2, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 3'b000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
